// File: rtl/y_stream_monitor_if.sv
// Bundles the sampled y code, its qualifiers and the monitor results into one port.
interface y_stream_monitor_if #(
    parameter int CNT_W = 8,
    parameter int RUN_W = 6
);
    logic [1:0]       y;
    logic             en;
    logic             clr;
    logic             det;
    logic [CNT_W-1:0] det_cnt;
    logic [RUN_W-1:0] run_len;
    logic [RUN_W-1:0] max_run;

    modport master (
        output y, en, clr,
        input  det, det_cnt, run_len, max_run
    );

    modport slave (
        input  y, en, clr,
        output det, det_cnt, run_len, max_run
    );
endinterface

// File: rtl/y_stream_monitor.sv
// Watches the 2-bit y stream for the 01,10,11 sequence and tracks run lengths of repeated codes.
//
// state  | meaning
// S_IDLE | no partial match
// S_G1   | last valid y was 01
// S_G2   | last two valid y were 01, 10
module y_stream_monitor #(
    parameter int CNT_W = 8,
    parameter int RUN_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    y_stream_monitor_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_G1, S_G2} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [RUN_W-1:0] RUN_MAX = '1;

    state_t           state_q, state_d;
    logic             det_q, det_d;
    logic [CNT_W-1:0] det_cnt_q, det_cnt_d;
    logic [RUN_W-1:0] run_len_q, run_len_d;
    logic [RUN_W-1:0] max_run_q, max_run_d;
    logic [1:0]       prev_y_q, prev_y_d;
    logic             have_prev_q, have_prev_d;
    logic             match;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            det_q       <= 1'b0;
            det_cnt_q   <= '0;
            run_len_q   <= '0;
            max_run_q   <= '0;
            prev_y_q    <= 2'b00;
            have_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            det_q       <= det_d;
            det_cnt_q   <= det_cnt_d;
            run_len_q   <= run_len_d;
            max_run_q   <= max_run_d;
            prev_y_q    <= prev_y_d;
            have_prev_q <= have_prev_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        det_d       = 1'b0;
        det_cnt_d   = det_cnt_q;
        run_len_d   = run_len_q;
        max_run_d   = max_run_q;
        prev_y_d    = prev_y_q;
        have_prev_d = have_prev_q;
        match       = 1'b0;

        if (bus.clr) begin
            state_d     = S_IDLE;
            det_cnt_d   = '0;
            run_len_d   = '0;
            max_run_d   = '0;
            prev_y_d    = 2'b00;
            have_prev_d = 1'b0;
        end else if (bus.en) begin
            case (state_q)
                S_IDLE:  state_d = (bus.y == 2'b01) ? S_G1 : S_IDLE;
                S_G1: begin
                    if (bus.y == 2'b10)      state_d = S_G2;
                    else if (bus.y == 2'b01) state_d = S_G1;
                    else                     state_d = S_IDLE;
                end
                S_G2: begin
                    if (bus.y == 2'b11) begin
                        match   = 1'b1;
                        state_d = S_IDLE;
                    end else if (bus.y == 2'b01) begin
                        state_d = S_G1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            // det keeps pulsing after the counter has saturated
            if (match) begin
                det_d = 1'b1;
                if (det_cnt_q != CNT_MAX) det_cnt_d = det_cnt_q + 1'b1;
            end

            if (!have_prev_q || bus.y != prev_y_q) run_len_d = {{(RUN_W-1){1'b0}}, 1'b1};
            else if (run_len_q != RUN_MAX)         run_len_d = run_len_q + 1'b1;

            if (run_len_d > max_run_q) max_run_d = run_len_d;
            prev_y_d    = bus.y;
            have_prev_d = 1'b1;
        end
    end

    assign bus.det     = det_q;
    assign bus.det_cnt = det_cnt_q;
    assign bus.run_len = run_len_q;
    assign bus.max_run = max_run_q;
endmodule
